// File: rtl/paralelo_serial_tx.sv
// Byte-to-serial transmitter: comma preamble after reset, then user bytes or idle fill, LSB first.
// Optional macro PS_TX_RESYNC_EN adds a resync_req input that restarts the preamble from ACTIVE.
module paralelo_serial_tx #(
   parameter int unsigned SYNC_COUNT = 4,
   parameter logic [7:0]  COMMA      = 8'hBC,
   parameter logic [7:0]  IDLE       = 8'h7C
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       valid_in,
`ifdef PS_TX_RESYNC_EN
   input  logic       resync_req,
`endif
   output logic       ready_out,
   output logic       serial_out,
   output logic       sync_done,
   output logic       byte_start
);

   typedef enum logic {ST_SYNC, ST_ACTIVE} state_t;

   localparam logic [3:0] SYNC_LAST = 4'(SYNC_COUNT);

   state_t     state, nxt_state;
   logic [2:0] bit_cnt;
   logic [7:0] byte_q, load_byte;
   logic [3:0] sync_cnt, nxt_sync_cnt;
   logic       first_load;
   logic       nxt_sync_done;
   logic       load;
   logic       resync;

`ifdef PS_TX_RESYNC_EN
   assign resync = resync_req;
`else
   assign resync = 1'b0;
`endif

   // The first edge after reset loads a byte even though bit_cnt did not wrap.
   assign load = first_load | (bit_cnt == 3'd7);

   assign ready_out = (bit_cnt == 3'd7) && (state == ST_ACTIVE || sync_cnt == SYNC_LAST) && !resync;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      load_byte     = COMMA;
      nxt_state     = state;
      nxt_sync_cnt  = sync_cnt;
      nxt_sync_done = sync_done;
      if (state == ST_SYNC) begin
         nxt_sync_cnt = sync_cnt + 4'd1;
         if (nxt_sync_cnt == SYNC_LAST) nxt_state = ST_ACTIVE;
      end else if (resync) begin
         nxt_sync_cnt  = 4'd1;
         nxt_sync_done = 1'b0;
         nxt_state     = (SYNC_LAST == 4'd1) ? ST_ACTIVE : ST_SYNC;
      end else begin
         load_byte     = valid_in ? data_in : IDLE;
         nxt_sync_done = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_32f) begin
      if (reset) begin
         state      <= ST_SYNC;
         bit_cnt    <= 3'd0;
         byte_q     <= 8'd0;
         sync_cnt   <= 4'd0;
         first_load <= 1'b1;
         serial_out <= 1'b0;
         sync_done  <= 1'b0;
         byte_start <= 1'b0;
      end else if (load) begin
         state      <= nxt_state;
         bit_cnt    <= 3'd0;
         byte_q     <= load_byte;
         sync_cnt   <= nxt_sync_cnt;
         first_load <= 1'b0;
         serial_out <= load_byte[0];
         sync_done  <= nxt_sync_done;
         byte_start <= 1'b1;
      end else begin
         bit_cnt    <= bit_cnt + 3'd1;
         serial_out <= byte_q[bit_cnt + 3'd1];
         byte_start <= 1'b0;
      end
   end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Scoreboard bench for paralelo_serial_tx: the driver queues expected line bytes,
// a negedge monitor pops them at each byte boundary and checks every bit and flag.
module tb_paralelo_serial_tx;

   localparam int         SC    = 4;
   localparam logic [7:0] COMMA = 8'hBC;
   localparam logic [7:0] IDLE  = 8'h7C;

   logic       clk_32f = 1'b0;
   logic       reset;
   logic [7:0] data_in;
   logic       valid_in;
   logic       ready_out, serial_out, sync_done, byte_start;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [7:0] exp_q[$];
   logic [7:0] cur = 8'h00;
   bit         running = 1'b0;
   int         cyc = 0;
   int         ph;

   paralelo_serial_tx #(.SYNC_COUNT(SC), .COMMA(COMMA), .IDLE(IDLE)) dut (
      .clk_32f    (clk_32f),
      .reset      (reset),
      .data_in    (data_in),
      .valid_in   (valid_in),
      .ready_out  (ready_out),
      .serial_out (serial_out),
      .sync_done  (sync_done),
      .byte_start (byte_start)
   );

   always #5 clk_32f = ~clk_32f;

   // Cycle index since reset release: cycle 0 follows the first edge with reset low.
   always @(posedge clk_32f) begin
      running <= !reset;
      cyc     <= (reset || !running) ? 0 : cyc + 1;
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
      n_cmp++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s at t=%0t cyc=%0d: got %0h want %0h", name, $time, cyc, act, want);
      end
   endtask

   always @(negedge clk_32f) begin
      if (running) begin
         ph = cyc % 8;
         if (ph == 0) begin
            check("byte_start", {7'd0, byte_start}, 8'd1);
            check("exp_available", {7'd0, exp_q.size() != 0}, 8'd1);
            cur = (exp_q.size() != 0) ? exp_q.pop_front() : IDLE;
         end else begin
            check("byte_start", {7'd0, byte_start}, 8'd0);
         end
         check("serial_bit", {7'd0, serial_out}, {7'd0, cur[ph]});
         check("ready_out", {7'd0, ready_out}, {7'd0, (ph == 7) && (cyc >= 8*SC - 1)});
         check("sync_done", {7'd0, sync_done}, {7'd0, cyc >= 8*SC});
      end
   end

   task automatic next_cycle();
      @(posedge clk_32f);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      next_cycle();
      valid_in = 1'b0;
      check("rst_serial_out", {7'd0, serial_out}, 8'd0);
      check("rst_ready_out",  {7'd0, ready_out},  8'd0);
      check("rst_sync_done",  {7'd0, sync_done},  8'd0);
      check("rst_byte_start", {7'd0, byte_start}, 8'd0);
      exp_q.delete();
      next_cycle();
      reset = 1'b0;
      repeat (SC) exp_q.push_back(COMMA);
   endtask

   // Advance to the next cycle whose closing edge loads a user-side byte.
   task automatic wait_slot();
      int n = 0;
      while (!(running && (cyc % 8 == 7) && (cyc >= 8*SC - 1)) && n < 64) begin
         next_cycle();
         n++;
      end
      check("slot_reached", {7'd0, n < 64}, 8'd1);
   endtask

   task automatic send_slot(input bit v, input logic [7:0] d);
      wait_slot();
      valid_in = v;
      data_in  = d;
      exp_q.push_back(v ? d : IDLE);
      next_cycle();
      // Junk offered while ready_out is low must never reach the line.
      valid_in = 1'b1;
      data_in  = 8'h81;
   endtask

   initial begin
      reset    = 1'b1;
      valid_in = 1'b0;
      data_in  = 8'h00;
      do_reset();

      send_slot(1'b0, 8'h00);              // preamble then one idle byte
      repeat (3) send_slot(1'b1, 8'hA5);   // back-to-back user bytes
      send_slot(1'b1, 8'h3C);
      send_slot(1'b0, 8'h3C);              // no offer: idle fill, nothing lost
      send_slot(1'b1, 8'hFF);

      send_slot(1'b1, 8'hC3);              // reset while bit 3 is on the line
      repeat (3) next_cycle();
      do_reset();

      send_slot(1'b1, 8'h5A);
      wait_slot();                         // reset coincides with ready_out
      valid_in = 1'b1;
      data_in  = 8'hEE;
      do_reset();

      send_slot(1'b1, 8'h01);
      send_slot(1'b0, 8'h00);
      repeat (7) next_cycle();
      @(negedge clk_32f);
      #1;
      check("queue_drained", 8'(exp_q.size()), 8'd0);
      reset = 1'b1;
      next_cycle();
      next_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/paralelo_serial_tx.md
# paralelo_serial_tx

Byte-to-serial transmitter for the serial link, driving the line consumed by the serial-to-parallel receiver. It runs on the bit clock, with eight bit times per byte. After reset it emits a comma (0xBC) preamble so the receiver can lock. It then sends either user bytes or idle symbols (0x7C), least-significant bit first, one byte per eight clocks.

## Interface
- SYNC_COUNT, 4: number of consecutive comma bytes sent after reset; legal 1..15.
- COMMA, 8'hBC: comma/preamble symbol.
- IDLE, 8'h7C: idle fill symbol, sent when no user byte is offered.

Ports:
- clk_32f  input  1  bit clock; all logic on posedge; one clock only.
- reset  input  1  synchronous, active-high reset.
- data_in  input  8  user byte.
- valid_in  input  1  data_in holds a byte to send.
- ready_out  output  1  high in the cycle whose closing edge loads the next byte from the user side.
- serial_out  output  1  serial line, LSB first.
- sync_done  output  1  high once the comma preamble has fully left the line.
- byte_start  output  1  high while serial_out carries bit 0 of any byte.

## Operation
- Registers:
  - bit_cnt, 3 bits, free-running 0..7 and wrapping 7→0.
  - byte_q, 8 bits, the byte in flight.
  - sync_cnt, 4 bits.
  - state.
- States: SYNC and ACTIVE.
- SYNC:
  - At each load edge, byte_q ← COMMA and sync_cnt increments.
  - The load that brings sync_cnt to SYNC_COUNT moves the state to ACTIVE.
  - The next byte load then comes from the user side.
- ACTIVE:
  - At each load edge, byte_q ← data_in if valid_in=1, else IDLE.
  - State stays ACTIVE until reset.
- Load edge: the posedge at which bit_cnt goes 7→0, plus the first edge after reset deasserts.
- serial_out:
  - At a load edge, serial_out takes bit 0 of the byte being loaded.
  - At other edges, serial_out takes byte_q[bit_cnt+1].
- ready_out:
  - Decoded from registered state only; never from valid_in.
  - Equals (bit_cnt==7) & (state==ACTIVE | sync_cnt==SYNC_COUNT).
- Handshake:
  - A byte is consumed exactly when ready_out=1 and valid_in=1 at the same edge.
  - If valid_in=0 while ready_out=1, one IDLE byte is sent and no user byte is lost.
  - data_in is ignored whenever ready_out=0.
- sync_done:
  - Set at the edge where the last preamble bit finishes, i.e. the first ACTIVE load edge.
  - Cleared only by reset.
- Reset mid-byte: the partial byte is abandoned immediately and the preamble restarts in full.

## Timing
- Values while reset=1 and at the first edge with reset=1:
  - serial_out=0, ready_out=0, sync_done=0, byte_start=0.
  - bit_cnt=0, sync_cnt=0, state=SYNC.
- The first posedge with reset=0 is a load edge:
  - serial_out=COMMA[0].
  - byte_start=1.
- Each byte occupies exactly 8 consecutive cycles; there are no gaps between bytes.
- Latency: a byte accepted at edge N has bit k on serial_out during cycles N+k, for k=0..7.
- The first user byte can be accepted at the edge ending cycle 8·SYNC_COUNT−1 after reset release.
- No backpressure: ready_out is high exactly 1 cycle in every 8 once preamble loading completes.
- Simultaneous reset=1 and ready_out=1: reset wins and no byte is consumed.

## Configuration
- PS_TX_RESYNC_EN defined:
  - Adds input resync_req (1 bit).
  - If resync_req=1 at any load edge in ACTIVE, that load takes COMMA instead of user data, and sync_cnt←1.
  - State returns to SYNC and sync_done←0.
  - The preamble of SYNC_COUNT commas is then sent and ACTIVE resumes as after reset.
  - ready_out is forced to 0 during the cycle in which resync_req=1.
- PS_TX_RESYNC_EN undefined:
  - The port is absent.
  - The preamble occurs only after reset.

## Test plan
- Reset release with SYNC_COUNT=4, valid_in=0:
  - serial_out repeats 0,0,1,1,1,1,0,1 four times, then 0,0,1,1,1,1,1,0 (0x7C).
  - sync_done rises at edge 32.
- valid_in held at 1 with data_in=0xA5 from preamble end:
  - ready_out pulses every 8 cycles.
  - Each byte shows 1,0,1,0,0,1,0,1.
  - byte_start is aligned with bit 0.
- valid_in toggling per byte (0x3C, none, 0xFF):
  - Line carries 0x3C, 0x7C, 0xFF contiguously with no dropped or duplicated bytes.
- Reset asserted at bit 3 of a user byte:
  - Next cycle serial_out=0, ready_out=0, sync_done=0.
  - After release, the full 4-comma preamble restarts.
- Loopback into the serial-to-parallel receiver:
  - Receiver idle indication asserts after the 4 commas plus one idle byte.
- PS_TX_RESYNC_EN with resync_req pulsed at a load edge while sending 0x55 traffic:
  - 4 commas are emitted.
  - sync_done drops, then re-rises.
  - 0x55 traffic resumes.
